// File: rtl/apb_master_bridge_if.sv
// Bundles the local command/response handshake and the APB4 requester signals of apb_master_bridge.
// The master modport is the bridge's view; the slave modport is the surrounding system's view.
interface apb_master_bridge_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic [STRB_WIDTH-1:0] cmd_strb;
   logic [2:0]            cmd_prot;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_slverr;
   logic                  rsp_timeout;

   logic [ADDR_WIDTH-1:0] paddr;
   logic [2:0]            pprot;
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [STRB_WIDTH-1:0] pstrb;
   logic                  pready;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pslverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
      input  rsp_ready, pready, prdata, pslverr,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
      output paddr, pprot, psel, penable, pwrite, pwdata, pstrb
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
      output rsp_ready, pready, prdata, pslverr,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
      input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb
   );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB4 requester: one command in, one SETUP/ACCESS transfer, one response out.
// Stalled ACCESS phases are aborted after TIMEOUT_CYCLES cycles (0 disables the abort).
module apb_master_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic                 pclk,
   input logic                 preset,
   apb_master_bridge_if.master bus
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int CNT_WIDTH  = $clog2(TIMEOUT_CYCLES + 2);
   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3} state_t;

   state_t                state, state_nxt;
   logic [CNT_WIDTH-1:0]  wait_cnt, cnt_nxt;
   logic                  psel_nxt, penable_nxt, pwrite_nxt;
   logic [ADDR_WIDTH-1:0] paddr_nxt;
   logic [DATA_WIDTH-1:0] pwdata_nxt, rdata_nxt;
   logic [STRB_WIDTH-1:0] pstrb_nxt;
   logic [2:0]            pprot_nxt;
   logic                  rsp_valid_nxt, slverr_nxt, timeout_nxt;

   assign bus.cmd_ready = (state == IDLE);

   // Next-state and next-register-value decode; everything holds unless a state says otherwise.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = wait_cnt;
      psel_nxt      = bus.psel;
      penable_nxt   = bus.penable;
      pwrite_nxt    = bus.pwrite;
      paddr_nxt     = bus.paddr;
      pwdata_nxt    = bus.pwdata;
      pstrb_nxt     = bus.pstrb;
      pprot_nxt     = bus.pprot;
      rsp_valid_nxt = bus.rsp_valid;
      rdata_nxt     = bus.rsp_rdata;
      slverr_nxt    = bus.rsp_slverr;
      timeout_nxt   = bus.rsp_timeout;
      case (state)
         IDLE: begin
            cnt_nxt = {CNT_WIDTH{1'b0}};
            if (bus.cmd_valid) begin
               state_nxt   = SETUP;
               psel_nxt    = 1'b1;
               penable_nxt = 1'b0;
               pwrite_nxt  = bus.cmd_write;
               paddr_nxt   = bus.cmd_addr;
               pwdata_nxt  = bus.cmd_wdata;
               pstrb_nxt   = bus.cmd_write ? bus.cmd_strb : {STRB_WIDTH{1'b0}};
               pprot_nxt   = bus.cmd_prot;
            end else begin
               state_nxt = IDLE;
            end
         end
         SETUP: begin
            state_nxt   = ACCESS;
            penable_nxt = 1'b1;
            cnt_nxt     = {CNT_WIDTH{1'b0}};
         end
         ACCESS: begin
            // A completing pready wins over a timeout expiring on the same edge.
            if (bus.pready) begin
               state_nxt     = RESP;
               psel_nxt      = 1'b0;
               penable_nxt   = 1'b0;
               rsp_valid_nxt = 1'b1;
               rdata_nxt     = bus.pwrite ? {DATA_WIDTH{1'b0}} : bus.prdata;
               slverr_nxt    = bus.pslverr;
               timeout_nxt   = 1'b0;
            end else if (TIMEOUT_EN && (wait_cnt == CNT_LAST)) begin
               state_nxt     = RESP;
               psel_nxt      = 1'b0;
               penable_nxt   = 1'b0;
               rsp_valid_nxt = 1'b1;
               rdata_nxt     = {DATA_WIDTH{1'b0}};
               slverr_nxt    = 1'b1;
               timeout_nxt   = 1'b1;
            end else begin
               cnt_nxt = wait_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_nxt     = IDLE;
               rsp_valid_nxt = 1'b0;
            end else begin
               state_nxt = RESP;
            end
         end
         default: begin
            state_nxt     = IDLE;
            psel_nxt      = 1'b0;
            penable_nxt   = 1'b0;
            rsp_valid_nxt = 1'b0;
         end
      endcase
   end

   // State, counter and all registered outputs.
   always_ff @(posedge pclk) begin
      if (preset) begin
         state           <= IDLE;
         wait_cnt        <= {CNT_WIDTH{1'b0}};
         bus.psel        <= 1'b0;
         bus.penable     <= 1'b0;
         bus.pwrite      <= 1'b0;
         bus.paddr       <= {ADDR_WIDTH{1'b0}};
         bus.pwdata      <= {DATA_WIDTH{1'b0}};
         bus.pstrb       <= {STRB_WIDTH{1'b0}};
         bus.pprot       <= 3'b000;
         bus.rsp_valid   <= 1'b0;
         bus.rsp_rdata   <= {DATA_WIDTH{1'b0}};
         bus.rsp_slverr  <= 1'b0;
         bus.rsp_timeout <= 1'b0;
      end else begin
         state           <= state_nxt;
         wait_cnt        <= cnt_nxt;
         bus.psel        <= psel_nxt;
         bus.penable     <= penable_nxt;
         bus.pwrite      <= pwrite_nxt;
         bus.paddr       <= paddr_nxt;
         bus.pwdata      <= pwdata_nxt;
         bus.pstrb       <= pstrb_nxt;
         bus.pprot       <= pprot_nxt;
         bus.rsp_valid   <= rsp_valid_nxt;
         bus.rsp_rdata   <= rdata_nxt;
         bus.rsp_slverr  <= slverr_nxt;
         bus.rsp_timeout <= timeout_nxt;
      end
   end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: table of directed transfers against an 8-register APB slave model at
// base 0x08, plus hand-written backpressure and reset-during-ACCESS sequences.
module tb_apb_master_bridge;
   logic pclk;
   logic preset;
   int   errors = 0;
   int   checks = 0;

   apb_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
      .pclk  (pclk),
      .preset(preset),
      .bus   (bus)
   );

   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   // Slave model: registers 0x08..0x24, s_waits wait cycles per access, s_hang never completes.
   int          s_waits = 0;
   logic        s_hang  = 1'b0;
   int          acc_cnt;
   logic [31:0] regs [8];
   logic [31:0] off;
   logic [2:0]  idx;
   logic        in_rng;

   assign off          = bus.paddr - 32'd8;
   assign idx          = off[4:2];
   assign in_rng       = (bus.paddr >= 32'h8) && (bus.paddr < 32'h28) && (bus.paddr[1:0] == 2'b00);
   assign bus.prdata   = in_rng ? regs[idx] : 32'h0;
   assign bus.pslverr  = ~in_rng;
   assign bus.pready   = bus.psel && bus.penable && !s_hang && (acc_cnt >= s_waits);

   always_ff @(posedge pclk) begin
      if (preset) begin
         acc_cnt <= 0;
         for (int i = 0; i < 8; i++) regs[i] <= 32'h0;
      end else begin
         acc_cnt <= (bus.psel && bus.penable && !bus.pready) ? acc_cnt + 1 : 0;
         if (bus.psel && bus.penable && bus.pready && bus.pwrite && in_rng) begin
            for (int b = 0; b < 4; b++)
               if (bus.pstrb[b]) regs[idx][8*b +: 8] <= bus.pwdata[8*b +: 8];
         end
      end
   end

   // Bus monitor: running totals of select/enable cycles and request changes inside a transfer.
   int           psel_tot = 0;
   int           pen_tot  = 0;
   int           unst_tot = 0;
   logic         prev_psel = 1'b0;
   logic [103:0] prev_req;
   logic [103:0] cur_req;
   assign cur_req = {bus.paddr, bus.pwdata, bus.pstrb, bus.pprot, bus.pwrite, 32'h0};

   always @(negedge pclk) begin
      if (bus.psel) psel_tot++;
      if (bus.penable) pen_tot++;
      if (bus.psel && prev_psel && (cur_req != prev_req)) unst_tot++;
      prev_psel = bus.psel;
      prev_req  = cur_req;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          waits;
      logic        hang;
      logic [31:0] exp_rdata;
      logic        exp_slverr;
      logic        exp_tmo;
      int          exp_lat;
      int          exp_psel;
      int          exp_pen;
   } vec_t;

   task automatic do_xfer(input vec_t v, output logic [31:0] rdata, output logic slverr,
                          output logic tmo, output int lat);
      int n;
      s_waits = v.waits;
      s_hang  = v.hang;
      @(negedge pclk);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = v.write;
      bus.cmd_addr  = v.addr;
      bus.cmd_wdata = v.wdata;
      bus.cmd_strb  = v.strb;
      bus.cmd_prot  = 3'b010;
      n = 0;
      while (!bus.cmd_ready && n < 20) begin
         @(negedge pclk);
         n++;
      end
      check("cmd_accept", 64'(bus.cmd_ready), 64'h1);
      @(posedge pclk);
      #1;
      bus.cmd_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge pclk);
         lat++;
      end while (!bus.rsp_valid && lat < 100);
      rdata  = bus.rsp_rdata;
      slverr = bus.rsp_slverr;
      tmo    = bus.rsp_timeout;
      bus.rsp_ready = 1'b1;
      @(posedge pclk);
      #1;
      bus.rsp_ready = 1'b0;
   endtask

   vec_t vecs [13];

   initial begin
      logic [31:0] rd;
      logic        se;
      logic        to;
      logic [31:0] r0;
      int          lat;
      int          ps0;
      int          pe0;
      int          un0;
      int          n;
      logic        bad_ready;
      logic        bad_psel;
      logic        bad_rsp;

      //         wr    addr    wdata         strb   w  hang  rdata         err   tmo  lat psel pen
      vecs[0]  = '{1'b1, 32'h0C, 32'hA5A5_0001, 4'hF, 0, 1'b0, 32'h0,        1'b0, 1'b0, 3,  2,  1};
      vecs[1]  = '{1'b0, 32'h0C, 32'h0,         4'hF, 0, 1'b0, 32'hA5A5_0001, 1'b0, 1'b0, 3,  2,  1};
      vecs[2]  = '{1'b1, 32'h0C, 32'h0000_FF00, 4'h2, 0, 1'b0, 32'h0,        1'b0, 1'b0, 3,  2,  1};
      vecs[3]  = '{1'b0, 32'h0C, 32'h0,         4'hF, 0, 1'b0, 32'hA5A5_FF01, 1'b0, 1'b0, 3,  2,  1};
      vecs[4]  = '{1'b1, 32'h08, 32'h1234_5678, 4'h3, 0, 1'b0, 32'h0,        1'b0, 1'b0, 3,  2,  1};
      vecs[5]  = '{1'b0, 32'h08, 32'h0,         4'hF, 0, 1'b0, 32'h0000_5678, 1'b0, 1'b0, 3,  2,  1};
      vecs[6]  = '{1'b1, 32'h10, 32'hDEAD_BEEF, 4'hC, 1, 1'b0, 32'h0,        1'b0, 1'b0, 4,  3,  2};
      vecs[7]  = '{1'b0, 32'h10, 32'h0,         4'hF, 3, 1'b0, 32'hDEAD_0000, 1'b0, 1'b0, 6,  5,  4};
      vecs[8]  = '{1'b0, 32'h04, 32'h0,         4'hF, 0, 1'b0, 32'h0,        1'b1, 1'b0, 3,  2,  1};
      vecs[9]  = '{1'b1, 32'h30, 32'h1111_1111, 4'hF, 0, 1'b0, 32'h0,        1'b1, 1'b0, 3,  2,  1};
      vecs[10] = '{1'b0, 32'h24, 32'h0,         4'hF, 0, 1'b0, 32'h0,        1'b0, 1'b0, 3,  2,  1};
      vecs[11] = '{1'b0, 32'h0C, 32'h0,         4'hF, 0, 1'b1, 32'h0,        1'b1, 1'b1, 18, 17, 16};
      vecs[12] = '{1'b0, 32'h0C, 32'h0,         4'hF, 0, 1'b0, 32'hA5A5_FF01, 1'b0, 1'b0, 3,  2,  1};

      preset        = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'h0;
      bus.cmd_wdata = 32'h0;
      bus.cmd_strb  = 4'h0;
      bus.cmd_prot  = 3'b000;
      bus.rsp_ready = 1'b0;
      repeat (3) @(posedge pclk);
      #1;
      check("rst_psel", 64'(bus.psel), 64'h0);
      check("rst_penable", 64'(bus.penable), 64'h0);
      check("rst_pwrite", 64'(bus.pwrite), 64'h0);
      check("rst_paddr", 64'(bus.paddr), 64'h0);
      check("rst_pwdata", 64'(bus.pwdata), 64'h0);
      check("rst_pstrb", 64'(bus.pstrb), 64'h0);
      check("rst_pprot", 64'(bus.pprot), 64'h0);
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
      check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'h0);
      check("rst_rsp_slverr", 64'(bus.rsp_slverr), 64'h0);
      check("rst_rsp_timeout", 64'(bus.rsp_timeout), 64'h0);
      check("rst_cmd_ready", 64'(bus.cmd_ready), 64'h1);
      @(negedge pclk);
      preset = 1'b0;

      for (int i = 0; i < 13; i++) begin
         ps0 = psel_tot;
         pe0 = pen_tot;
         un0 = unst_tot;
         do_xfer(vecs[i], rd, se, to, lat);
         check($sformatf("v%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
         check($sformatf("v%0d_slverr", i), 64'(se), 64'(vecs[i].exp_slverr));
         check($sformatf("v%0d_timeout", i), 64'(to), 64'(vecs[i].exp_tmo));
         check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
         check($sformatf("v%0d_psel_cycles", i), 64'(psel_tot - ps0), 64'(vecs[i].exp_psel));
         check($sformatf("v%0d_penable_cycles", i), 64'(pen_tot - pe0), 64'(vecs[i].exp_pen));
         check($sformatf("v%0d_apb_changes", i), 64'(unst_tot - un0), 64'h0);
      end

      // Response backpressure with a second command already waiting.
      s_waits = 0;
      s_hang  = 1'b0;
      @(negedge pclk);
      check("bp_idle_ready", 64'(bus.cmd_ready), 64'h1);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'h0C;
      @(posedge pclk);
      #1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 32'h20;
      bus.cmd_wdata = 32'h5A5A_5A5A;
      bus.cmd_strb  = 4'hF;
      n = 0;
      do begin
         @(negedge pclk);
         n++;
      end while (!bus.rsp_valid && n < 100);
      r0        = bus.rsp_rdata;
      bad_ready = bus.cmd_ready;
      bad_psel  = 1'b0;
      bad_rsp   = 1'b0;
      repeat (5) begin
         @(negedge pclk);
         bad_ready = bad_ready | bus.cmd_ready;
         bad_psel  = bad_psel | bus.psel;
         bad_rsp   = bad_rsp | !bus.rsp_valid | (bus.rsp_rdata != r0) | bus.rsp_slverr | bus.rsp_timeout;
      end
      check("bp_rdata", 64'(r0), 64'hA5A5_FF01);
      check("bp_cmd_ready_low", 64'(bad_ready), 64'h0);
      check("bp_no_psel", 64'(bad_psel), 64'h0);
      check("bp_rsp_stable", 64'(bad_rsp), 64'h0);
      bus.rsp_ready = 1'b1;
      @(posedge pclk);
      #1;
      bus.rsp_ready = 1'b0;
      @(negedge pclk);
      check("bp_psel_after_consume", 64'(bus.psel), 64'h0);
      @(negedge pclk);
      check("bp_second_psel", 64'(bus.psel), 64'h1);
      bus.cmd_valid = 1'b0;
      n = 0;
      do begin
         @(negedge pclk);
         n++;
      end while (!bus.rsp_valid && n < 100);
      check("bp_second_slverr", 64'(bus.rsp_slverr), 64'h0);
      check("bp_second_latency", 64'(n), 64'h2);
      bus.rsp_ready = 1'b1;
      @(posedge pclk);
      #1;
      bus.rsp_ready = 1'b0;

      // Reset while the slave stalls in ACCESS.
      s_hang = 1'b1;
      @(negedge pclk);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'h14;
      bus.cmd_strb  = 4'hF;
      bus.cmd_prot  = 3'b101;
      @(posedge pclk);
      #1;
      bus.cmd_valid = 1'b0;
      n = 0;
      do begin
         @(negedge pclk);
         n++;
      end while (!bus.penable && n < 50);
      repeat (2) @(negedge pclk);
      check("rs_paddr", 64'(bus.paddr), 64'h14);
      check("rs_pprot", 64'(bus.pprot), 64'h5);
      check("rs_pstrb_read", 64'(bus.pstrb), 64'h0);
      check("rs_pwrite", 64'(bus.pwrite), 64'h0);
      check("rs_in_access", 64'({bus.psel, bus.penable}), 64'h3);
      preset = 1'b1;
      @(posedge pclk);
      #1;
      check("rs_psel", 64'(bus.psel), 64'h0);
      check("rs_penable", 64'(bus.penable), 64'h0);
      check("rs_rsp_valid", 64'(bus.rsp_valid), 64'h0);
      check("rs_cmd_ready", 64'(bus.cmd_ready), 64'h1);
      check("rs_paddr_cleared", 64'(bus.paddr), 64'h0);
      @(negedge pclk);
      preset = 1'b0;
      s_hang = 1'b0;
      repeat (2) @(negedge pclk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
